// File: rtl/pll_reconf_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pll_reconf_ctrl
//
// Initiator side of the rPLL dynamic-divider interface. Every divider change
// is sequenced as follows:
//   1. Drive the new codes with the PLL held in reset.
//   2. Hold reset for RESET_CYCLES cycles, then release it.
//   3. Wait for SETTLE_CYCLES consecutive synchronised lock-high cycles.
//   4. Report done, or report an error after LOCK_TIMEOUT cycles.
// The block runs on the PLL reference clock, never on the PLL output.
//
// Optional feature macro: PLL_RECONF_RETRY_EN
//   When defined, a lock timeout re-runs the reset sequence with the same
//   codes up to MAX_RETRIES times before entering ERR. When undefined, a
//   timeout goes straight to ERR and no retry counter is built.
//
// Ports:
//   clkin      in   reference clock (only clock)
//   resetn     in   synchronous active-low reset; restarts the power-up
//                   sequence using FDIV_INIT/IDIV_INIT
//   req_valid  in   new divider request
//   req_ready  out  request can be accepted (IDLE or ERR, not on done cycle)
//   req_fdiv   in   requested feedback-divider code (PLL encoding)
//   req_idiv   in   requested input-divider code (PLL encoding)
//   pll_fdiv   out  registered code to PLL fdiv (FBDSEL)
//   pll_idiv   out  registered code to PLL idiv (IDSEL)
//   pll_reset  out  registered PLL reset, active high
//   pll_lock   in   PLL lock_o, asynchronous to clkin
//   busy       out  sequence in progress (APPLY or WAIT_LOCK)
//   done       out  one-cycle pulse when lock has settled
//   err        out  sticky lock-timeout flag, cleared on next accepted request
//   locked     out  synchronised lock, only while IDLE
// ---------------------------------------------------------------------------
module pll_reconf_ctrl #(
  parameter logic [5:0]  FDIV_INIT     = 6'd0,
  parameter logic [5:0]  IDIV_INIT     = 6'd0,
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_fdiv,
  input  logic [5:0] req_idiv,
  output logic [5:0] pll_fdiv,
  output logic [5:0] pll_idiv,
  output logic       pll_reset,
  input  logic       pll_lock,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       locked
);

  // Reject parameter sets that would make the counters meaningless.
  if (RESET_CYCLES < 1 || SETTLE_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
      MAX_RETRIES > 32'h0000_FFFF) begin : g_param_check
    $error("pll_reconf_ctrl: RESET_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT must be >= 1 and MAX_RETRIES <= 65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_APPLY     = 2'd1,
    ST_WAIT_LOCK = 2'd2,
    ST_ERR       = 2'd3
  } state_t;

  localparam int RCW = (RESET_CYCLES < 1)  ? 1 : $clog2(RESET_CYCLES + 1);
  localparam int SCW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int TCW = (LOCK_TIMEOUT < 1)  ? 1 : $clog2(LOCK_TIMEOUT + 1);

  // The APPLY counter starts at 0 on the first reset-high cycle, so the last
  // reset-high cycle is the one where it reads RESET_CYCLES-1.
  localparam logic [RCW-1:0] APPLY_LAST     = RCW'(RESET_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_TARGET  = SCW'(SETTLE_CYCLES);
  localparam logic [TCW-1:0] TIMEOUT_TARGET = TCW'(LOCK_TIMEOUT);

  state_t         state_q;
  logic [5:0]     fdiv_q;
  logic [5:0]     idiv_q;
  logic           pll_reset_q;
  logic           done_q;
  logic           err_q;
  logic [RCW-1:0] apply_cnt_q;
  logic [RCW-1:0] apply_cnt_d;
  logic [SCW-1:0] settle_q;
  logic [SCW-1:0] settle_d;
  logic [TCW-1:0] timeout_q;
  logic [TCW-1:0] timeout_d;
  logic           lock_meta_q;
  logic           lock_s_q;
  logic           accept;

`ifdef PLL_RECONF_RETRY_EN
  localparam int RTW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [RTW-1:0] RETRY_LIMIT = RTW'(MAX_RETRIES);

  logic [RTW-1:0] retry_q;
  logic           retry_ok;

  assign retry_ok = (retry_q < RETRY_LIMIT);
`endif

  // -------------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous lock indication.
  // -------------------------------------------------------------------------
  always_ff @(posedge clkin) begin
    if (!resetn) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Counters only ever count up to their target and then the state changes,
  // so none of them can wrap.
  assign apply_cnt_d = apply_cnt_q + RCW'(1);
  assign settle_d    = lock_s_q ? (settle_q + SCW'(1)) : '0;
  assign timeout_d   = timeout_q + TCW'(1);

  // The done pulse coincides with the first IDLE cycle; masking ready there
  // keeps done and req_ready mutually exclusive.
  assign req_ready = ((state_q == ST_IDLE) || (state_q == ST_ERR)) && !done_q;
  assign accept    = req_valid && req_ready;

  // -------------------------------------------------------------------------
  // Sequencer. Reset enters APPLY directly so the power-up sequence is the
  // same as any other divider change, using the INIT codes.
  // -------------------------------------------------------------------------
  always_ff @(posedge clkin) begin
    if (!resetn) begin
      state_q     <= ST_APPLY;
      fdiv_q      <= FDIV_INIT;
      idiv_q      <= IDIV_INIT;
      pll_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      apply_cnt_q <= '0;
      settle_q    <= '0;
      timeout_q   <= '0;
`ifdef PLL_RECONF_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;

      case (state_q)
        // ERR behaves like IDLE for new requests; only the PLL reset level
        // and the err flag differ, and both are already registered.
        ST_IDLE, ST_ERR: begin
          if (accept) begin
            fdiv_q      <= req_fdiv;
            idiv_q      <= req_idiv;
            pll_reset_q <= 1'b1;
            err_q       <= 1'b0;
            apply_cnt_q <= '0;
`ifdef PLL_RECONF_RETRY_EN
            retry_q     <= '0;
`endif
            state_q     <= ST_APPLY;
          end
        end

        ST_APPLY: begin
          if (apply_cnt_q == APPLY_LAST) begin
            pll_reset_q <= 1'b0;
            settle_q    <= '0;
            timeout_q   <= '0;
            state_q     <= ST_WAIT_LOCK;
          end else begin
            apply_cnt_q <= apply_cnt_d;
          end
        end

        ST_WAIT_LOCK: begin
          settle_q  <= settle_d;
          timeout_q <= timeout_d;
          // Settling is checked first so that a lock completing on the
          // timeout cycle still counts as a success.
          if (settle_d == SETTLE_TARGET) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (timeout_d == TIMEOUT_TARGET) begin
`ifdef PLL_RECONF_RETRY_EN
            if (retry_ok) begin
              // Re-run the reset pulse with the codes already on the bus.
              retry_q     <= retry_q + RTW'(1);
              apply_cnt_q <= '0;
              pll_reset_q <= 1'b1;
              state_q     <= ST_APPLY;
            end else begin
              err_q       <= 1'b1;
              pll_reset_q <= 1'b1;
              state_q     <= ST_ERR;
            end
`else
            err_q       <= 1'b1;
            pll_reset_q <= 1'b1;
            state_q     <= ST_ERR;
`endif
          end
        end

        default: begin
          pll_reset_q <= 1'b1;
          apply_cnt_q <= '0;
          state_q     <= ST_APPLY;
        end
      endcase
    end
  end

  assign pll_fdiv  = fdiv_q;
  assign pll_idiv  = idiv_q;
  assign pll_reset = pll_reset_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q == ST_APPLY) || (state_q == ST_WAIT_LOCK);
  assign locked    = lock_s_q && (state_q == ST_IDLE);

endmodule
